// File: rtl/hadamard8_pipe.sv
// -----------------------------------------------------------------------------
// hadamard8_pipe
//
// Pipelined 8-point 1-D Walsh-Hadamard transform stage. One 8-lane row vector is
// accepted per cycle. Each result is normalised by 1/8 and returned at BW bits
// with a valid flag and an end-of-block marker. The output feeds the transpose
// memory directly.
//
// Pipeline: S1 (distance-4 butterflies) -> S2 (distance 2) -> S3 (distance 1)
//           -> output stage (>>> 3, optional round + saturate). Latency 4 cycles.
//
// Build option:
//   HADAMARD_ROUND_EN  defined   : o = sat((y + 4) >>> 3), round-half-up
//                      undefined : o = y >>> 3, floor (always fits in BW bits)
//
// Ports:
//   i_clk     in   1      clock, rising edge
//   i_Reset   in   1      synchronous active-high reset
//   i_data    in   8*BW   input vector, lane k = i_data[(8-k)*BW-1 -: BW]
//   i_enable  in   1      input valid
//   o_data    out  8*BW   transformed vector, same lane packing
//   o_en      out  1      output valid
//   o_last    out  1      valid output carrying row 7 of an 8-row block
// -----------------------------------------------------------------------------
module hadamard8_pipe #(
  parameter int BW = 12
) (
  input  logic            i_clk,
  input  logic            i_Reset,
  input  logic [8*BW-1:0] i_data,
  input  logic            i_enable,
  output logic [8*BW-1:0] o_data,
  output logic            o_en,
  output logic            o_last
);

  logic signed [BW-1:0] x    [8];
  logic signed [BW:0]   s1_d [8];
  logic signed [BW:0]   s1   [8];
  logic signed [BW+1:0] s2_d [8];
  logic signed [BW+1:0] s2   [8];
  logic signed [BW+2:0] s3_d [8];
  logic signed [BW+2:0] s3   [8];
  logic [BW-1:0]        res  [8];
  logic [3:0]           vld;
  logic [2:0]           blk_cnt;

  // The three fractional bits dropped by the normalising shift.
  logic [23:0]          low_bits;
  logic                 unused_low;

`ifdef HADAMARD_ROUND_EN
  logic [BW+3:0]        yr [8];
  logic [BW:0]          yt [8];
`endif

  // Input lane unpacking: lane 0 is the MSB slice.
  always_comb begin
    for (int k = 0; k < 8; k++) begin
      x[k] = i_data[(8-k)*BW-1 -: BW];
    end
  end

  // S1: distance-4 butterflies, BW+1 bits.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      s1_d[i] = '0;
    end
    for (int i = 0; i < 4; i++) begin
      s1_d[i]   = {x[i][BW-1], x[i]} + {x[i+4][BW-1], x[i+4]};
      s1_d[i+4] = {x[i][BW-1], x[i]} - {x[i+4][BW-1], x[i+4]};
    end
  end

  // S2: distance-2 butterflies inside each half, BW+2 bits.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      s2_d[i] = '0;
    end
    for (int b = 0; b < 8; b += 4) begin
      for (int i = 0; i < 2; i++) begin
        s2_d[b+i]   = {s1[b+i][BW], s1[b+i]} + {s1[b+i+2][BW], s1[b+i+2]};
        s2_d[b+i+2] = {s1[b+i][BW], s1[b+i]} - {s1[b+i+2][BW], s1[b+i+2]};
      end
    end
  end

  // S3: distance-1 butterflies on adjacent pairs, BW+3 bits. The in-place
  // ordering of the three stages leaves the result in natural Hadamard order.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      s3_d[i] = '0;
    end
    for (int p = 0; p < 8; p += 2) begin
      s3_d[p]   = {s2[p][BW+1], s2[p]} + {s2[p+1][BW+1], s2[p+1]};
      s3_d[p+1] = {s2[p][BW+1], s2[p]} - {s2[p+1][BW+1], s2[p+1]};
    end
  end

  // Output normalisation.
`ifdef HADAMARD_ROUND_EN
  always_comb begin
    low_bits = '0;
    for (int j = 0; j < 8; j++) begin
      yr[j] = {s3[j][BW+2], s3[j]} + (BW+4)'(4);
      yt[j] = yr[j][BW+3:3];
      low_bits[j*3 +: 3] = yr[j][2:0];
      // Only +2^(BW-1) can overflow; the two top bits disagree exactly then.
      if (yt[j][BW] != yt[j][BW-1]) begin
        res[j] = yt[j][BW] ? {1'b1, {(BW-1){1'b0}}} : {1'b0, {(BW-1){1'b1}}};
      end else begin
        res[j] = yt[j][BW-1:0];
      end
    end
  end
`else
  always_comb begin
    low_bits = '0;
    for (int j = 0; j < 8; j++) begin
      res[j] = s3[j][BW+2:3];
      low_bits[j*3 +: 3] = s3[j][2:0];
    end
  end
`endif

  assign unused_low = ^low_bits;

  // Data registers hold when their stage's valid-in is low, so o_data keeps the
  // last result through bubbles.
  always_ff @(posedge i_clk) begin
    if (i_Reset) begin
      vld     <= '0;
      blk_cnt <= '0;
      o_data  <= '0;
      for (int i = 0; i < 8; i++) begin
        s1[i] <= '0;
        s2[i] <= '0;
        s3[i] <= '0;
      end
    end else begin
      vld <= {vld[2:0], i_enable};
      if (i_enable) begin
        for (int i = 0; i < 8; i++) s1[i] <= s1_d[i];
      end
      if (vld[0]) begin
        for (int i = 0; i < 8; i++) s2[i] <= s2_d[i];
      end
      if (vld[1]) begin
        for (int i = 0; i < 8; i++) s3[i] <= s3_d[i];
      end
      if (vld[2]) begin
        for (int j = 0; j < 8; j++) o_data[(8-j)*BW-1 -: BW] <= res[j];
      end
      if (vld[3]) begin
        blk_cnt <= blk_cnt + 3'd1;
      end
    end
  end

  assign o_en   = vld[3];
  assign o_last = vld[3] && (blk_cnt == 3'd7);

endmodule

// File: tb/tb_hadamard8_pipe.sv
module tb_hadamard8_pipe;
  localparam int BW = 12;
`ifdef HADAMARD_ROUND_EN
  localparam int RND = 1;
`else
  localparam int RND = 0;
`endif

  logic            i_clk = 1'b0;
  logic            i_Reset;
  logic [8*BW-1:0] i_data;
  logic            i_enable;
  logic [8*BW-1:0] o_data;
  logic            o_en;
  logic            o_last;

  int checks   = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  hadamard8_pipe #(.BW(BW)) dut (
    .i_clk    (i_clk),
    .i_Reset  (i_Reset),
    .i_data   (i_data),
    .i_enable (i_enable),
    .o_data   (o_data),
    .o_en     (o_en),
    .o_last   (o_last)
  );

  function automatic logic [8*BW-1:0] pack8(input int v[8]);
    logic [8*BW-1:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[(8-k)*BW-1 -: BW] = BW'(v[k]);
    return r;
  endfunction

  function automatic logic [8*BW-1:0] impulse(input int x0);
    int v[8];
    v = '{0, 0, 0, 0, 0, 0, 0, 0};
    v[0] = x0;
    return pack8(v);
  endfunction

  function automatic logic [8*BW-1:0] flat(input int a);
    int v[8];
    for (int k = 0; k < 8; k++) v[k] = a;
    return pack8(v);
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  // Drives one vector and returns what the output shows around its arrival.
  task automatic run_vec(input logic [8*BW-1:0] vec, output logic en_pre,
                         output logic en_out, output logic [8*BW-1:0] data_out);
    i_data   = vec;
    i_enable = 1'b1;
    tick();
    i_enable = 1'b0;
    tick();
    tick();
    en_pre = o_en;
    tick();
    en_out   = o_en;
    data_out = o_data;
  endtask

  task automatic test_reset;
    i_Reset  = 1'b1;
    i_enable = 1'b1;
    i_data   = flat(100);
    tick();
    tick();
    checks++;
    if (o_data !== '0) begin failures++; $display("FAIL reset_data: got %h expected 0", o_data); end
    checks++;
    if (o_en !== 1'b0) begin failures++; $display("FAIL reset_en: got %b expected 0", o_en); end
    checks++;
    if (o_last !== 1'b0) begin failures++; $display("FAIL reset_last: got %b expected 0", o_last); end
    i_Reset  = 1'b0;
    i_enable = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      checks++;
      if (o_en !== 1'b0) begin failures++; $display("FAIL reset_drop n=%0d: got %b expected 0", n, o_en); end
    end
  endtask

  task automatic test_dc;
    logic pre, en;
    logic [8*BW-1:0] d, e;
    int y[8];
    y = '{100, 0, 0, 0, 0, 0, 0, 0};
    e = pack8(y);
    run_vec(flat(100), pre, en, d);
    checks++;
    if (pre !== 1'b0) begin failures++; $display("FAIL dc_latency_early: got %b expected 0", pre); end
    checks++;
    if (en !== 1'b1) begin failures++; $display("FAIL dc_en: got %b expected 1", en); end
    checks++;
    if (d !== e) begin failures++; $display("FAIL dc_data: got %h expected %h", d, e); end
  endtask

  task automatic test_impulse;
    logic pre, en;
    logic [8*BW-1:0] d, e;
    run_vec(impulse(80), pre, en, d);
    e = flat(10);
    checks++;
    if (en !== 1'b1 || d !== e) begin failures++; $display("FAIL impulse80: got en=%b %h expected %h", en, d, e); end
    run_vec(impulse(4), pre, en, d);
    e = flat(RND ? 1 : 0);
    checks++;
    if (d !== e) begin failures++; $display("FAIL impulse_pos4: got %h expected %h", d, e); end
    run_vec(impulse(-4), pre, en, d);
    e = flat(RND ? 0 : -1);
    checks++;
    if (d !== e) begin failures++; $display("FAIL impulse_neg4: got %h expected %h", d, e); end
  endtask

  task automatic test_ramp;
    logic pre, en;
    logic [8*BW-1:0] d, e;
    int x[8];
    int y[8];
    x = '{8, 16, 24, 32, 40, 48, 56, 64};
    y = '{36, -4, -8, 0, -16, 0, 0, 0};
    e = pack8(y);
    run_vec(pack8(x), pre, en, d);
    checks++;
    if (d !== e) begin failures++; $display("FAIL ramp: got %h expected %h", d, e); end
  endtask

  task automatic test_extremes;
    logic pre, en;
    logic [8*BW-1:0] d, e;
    int x[8];
    int y[8];
    x = '{2047, -2048, 2047, -2048, 2047, -2048, 2047, -2048};
    y = '{0, 2047, 0, 0, 0, 0, 0, 0};
    y[0] = RND ? 0 : -1;
    e = pack8(y);
    run_vec(pack8(x), pre, en, d);
    checks++;
    if (d !== e) begin failures++; $display("FAIL alternating_sat: got %h expected %h", d, e); end
    y = '{-2048, 0, 0, 0, 0, 0, 0, 0};
    e = pack8(y);
    run_vec(flat(-2048), pre, en, d);
    checks++;
    if (d !== e) begin failures++; $display("FAIL all_min: got %h expected %h", d, e); end
  endtask

  // 5 vectors, 2-cycle bubble, 5 vectors, 2-cycle gap, 6 more vectors.
  task automatic test_back_to_back;
    logic pat[20];
    int vin, vout;
    logic exp_en, exp_last;
    logic [8*BW-1:0] exp_data;
    pat = '{1,1,1,1,1,0,0,1,1,1,1,1,0,0,1,1,1,1,1,1};
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    vin = 0;
    vout = 0;
    exp_data = '0;
    for (int n = 0; n < 24; n++) begin
      if (n < 20 && pat[n]) begin
        vin++;
        i_enable = 1'b1;
        i_data   = impulse(8 * vin);
      end else begin
        i_enable = 1'b0;
        i_data   = '0;
      end
      tick();
      exp_en   = (n >= 3 && n - 3 < 20) ? pat[n-3] : 1'b0;
      exp_last = 1'b0;
      if (exp_en) begin
        vout++;
        exp_data = flat(vout);
        exp_last = (vout % 8 == 0);
      end
      checks++;
      if (o_en !== exp_en) begin failures++; $display("FAIL stream_en n=%0d: got %b expected %b", n, o_en, exp_en); end
      checks++;
      if (o_last !== exp_last) begin failures++; $display("FAIL stream_last n=%0d: got %b expected %b", n, o_last, exp_last); end
      checks++;
      if (o_data !== exp_data) begin failures++; $display("FAIL stream_data n=%0d: got %h expected %h", n, o_data, exp_data); end
    end
  endtask

  task automatic test_reset_flush;
    int vout;
    logic exp_en, exp_last;
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    for (int m = 1; m <= 3; m++) begin
      i_enable = 1'b1;
      i_data   = impulse(8 * m);
      tick();
    end
    i_enable = 1'b0;
    for (int n = 0; n < 4; n++) tick();
    for (int m = 20; m <= 22; m++) begin
      i_enable = 1'b1;
      i_data   = impulse(8 * m);
      tick();
    end
    i_Reset  = 1'b1;
    i_enable = 1'b1;
    i_data   = impulse(8 * 30);
    tick();
    checks++;
    if (o_data !== '0) begin failures++; $display("FAIL flush_data: got %h expected 0", o_data); end
    checks++;
    if (o_en !== 1'b0) begin failures++; $display("FAIL flush_en: got %b expected 0", o_en); end
    checks++;
    if (o_last !== 1'b0) begin failures++; $display("FAIL flush_last: got %b expected 0", o_last); end
    i_Reset  = 1'b0;
    i_enable = 1'b0;
    for (int n = 0; n < 6; n++) begin
      tick();
      checks++;
      if (o_en !== 1'b0) begin failures++; $display("FAIL flush_quiet n=%0d: got %b expected 0", n, o_en); end
    end
    vout = 0;
    for (int n = 0; n < 12; n++) begin
      if (n < 8) begin
        i_enable = 1'b1;
        i_data   = impulse(8 * (n + 1));
      end else begin
        i_enable = 1'b0;
      end
      tick();
      exp_en   = (n >= 3 && n < 11);
      exp_last = (n == 10);
      checks++;
      if (o_en !== exp_en) begin failures++; $display("FAIL flush_row_en n=%0d: got %b expected %b", n, o_en, exp_en); end
      checks++;
      if (o_last !== exp_last) begin failures++; $display("FAIL flush_row_last n=%0d: got %b expected %b", n, o_last, exp_last); end
      if (exp_en) begin
        vout++;
        checks++;
        if (o_data !== flat(vout)) begin failures++; $display("FAIL flush_row_data n=%0d: got %h expected %h", n, o_data, flat(vout)); end
      end
    end
  endtask

  initial begin
    i_Reset  = 1'b1;
    i_enable = 1'b0;
    i_data   = '0;
    test_reset();
    test_dc();
    test_impulse();
    test_ramp();
    test_extremes();
    test_back_to_back();
    test_reset_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hadamard8_pipe.md
# hadamard8_pipe

- Pipelined 8-point 1-D Walsh-Hadamard transform stage for the 8x8 2-D transform datapath.
- Sits directly upstream of the transpose memory:
  - Accepts one 8-sample row vector per cycle.
  - Emits one normalised, BW-wide transformed vector per cycle, with a valid flag and an end-of-block marker.
- The output format feeds the transpose memory's `i_data`/`i_enable` with no glue logic.

## Interface
- `BW`, 12, sample width in bits; signed two's complement, for both input and output lanes.
- `i_clk`  in  1  single clock; all state updates on its rising edge.
- `i_Reset`  in  1  synchronous, active-high reset; sampled on the rising edge of `i_clk`.
- `i_data`  in  8*BW  input vector; lane k = `i_data[(8-k)*BW-1 -: BW]`, so lane 0 is the MSB slice.
- `i_enable`  in  1  input valid; `i_data` is sampled on every edge where it is high.
- `o_data`  out  8*BW  transformed vector; same lane packing as `i_data`.
- `o_en`  out  1  output valid.
- `o_last`  out  1  high with the 8th, 16th, ... valid output (row 7 of each 8-row block).

## Operation
- Transform: y[j] = sum over k=0..7 of (-1)^popcount(j AND k) * x[k], in natural (Hadamard) order.
- Three butterfly stages, each registered:
  - S1: distance 4 (a[i]±a[i+4]), width BW+1.
  - S2: distance 2, width BW+2.
  - S3: distance 1, width BW+3.
  - All adds are sign-extended; no overflow inside the stages.
- Output stage computes o = y >>> 3 (arithmetic), then saturates to [-2^(BW-1), 2^(BW-1)-1].
  - This stage is registered into `o_data`.
  - Rounding is configurable; see Configuration.
- Valid pipeline: a 4-bit shift of `i_enable` runs alongside the data.
  - A stage's data registers load only when that stage's valid-in is high; otherwise they hold.
  - Consequence: `o_data` holds the last valid result while `o_en` is low.
- Block counter: 3-bit, reset 0.
  - Increments on each cycle with `o_en` high; wraps 7→0.
  - `o_last` = `o_en` AND (count == 7), taken before the increment.
- There is no backpressure. The downstream stage must accept every `o_en` cycle.
- Bubbles (`i_enable` low) propagate unchanged and do not disturb the block counter.

## Timing
- `i_enable` high at edge t → `o_en` high with the result immediately after edge t+3 (4-cycle latency).
- Throughput: 1 vector/cycle sustained.
- Reset values: `o_data`=0, `o_en`=0, `o_last`=0, all stage registers 0, valid shift 0, block counter 0.
- Reset mid-operation: all in-flight vectors are discarded.
  - `o_en` stays low after reset release until a vector sampled after release reaches the output (3 edges later).
- `i_Reset` and `i_enable` both high on the same edge: reset wins and the input is dropped.
- Saturation applies only in the output stage. It is reachable only with rounding enabled, when a result equals +2^(BW-1) before clipping.

## Configuration
- `HADAMARD_ROUND_EN` defined:
  - o = sat((y + 4) >>> 3); round-half-up.
  - The +4 is added at BW+4 bits before the shift.
- `HADAMARD_ROUND_EN` undefined:
  - o = y >>> 3; floor truncation.
  - Saturation logic may be omitted, since the result always fits in BW.

## Test plan
- All lanes 100 → lane 0 = 100, lanes 1-7 = 0, `o_en` 4 cycles after input. Same result in both builds.
- Impulse: x0=80, others 0 → all lanes 10.
- x0=4, others 0 → all lanes 1 with `HADAMARD_ROUND_EN`, 0 without. x0=-4 → 0 with, -1 without.
- BW=12, alternating 2047,-2048 (lanes 0,2,4,6 = 2047) → lane 1 = 2047 in both builds (with rounding, 2048 saturates to 2047); lanes 0 and 2-7 = 0 with rounding, 0 or -1 by floor without. All lanes -2048 → lane 0 = -2048.
- Stream 10 vectors with a 2-cycle bubble after the 5th:
  - `o_en` pattern equals the input pattern delayed 4 cycles.
  - `o_last` is high only on the 8th valid output.
  - The counter reads 2 after the 10th output.
- Pulse `i_Reset` for 1 cycle with 3 vectors in flight → none of the 3 emerge. `o_data`=0, `o_en`=0, `o_last`=0 after the reset edge. The next vector's output is flagged as block row 0.
